// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: op codes, op classes and the stage entry record.
// Also imported by the 64-bit ALU.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_NOR = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    OPC_LDST   = 2'b00,
    OPC_BRANCH = 2'b01,
    OPC_RTYPE  = 2'b10,
    OPC_RSVD   = 2'b11
  } op_class_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] alu_ctrl;
    logic       illegal;
  } stage_entry_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of {op_class, funct7[5], funct3} into ALU op code and illegal flag.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] op_class_i,
  input  logic       funct7_5_i,
  input  logic [2:0] funct3_i,
  output logic [3:0] alu_ctrl_o,
  output logic       illegal_o
);

  always_comb begin
    alu_ctrl_o = ALU_NOR;
    illegal_o  = 1'b1;
    case (op_class_e'(op_class_i))
      OPC_LDST: begin
        alu_ctrl_o = ALU_ADD;
        illegal_o  = 1'b0;
      end
      OPC_BRANCH: begin
        alu_ctrl_o = ALU_SUB;
        illegal_o  = 1'b0;
      end
      OPC_RTYPE: begin
        case ({funct7_5_i, funct3_i})
          4'b0_000: begin alu_ctrl_o = ALU_ADD; illegal_o = 1'b0; end
          4'b1_000: begin alu_ctrl_o = ALU_SUB; illegal_o = 1'b0; end
          4'b0_111: begin alu_ctrl_o = ALU_AND; illegal_o = 1'b0; end
          4'b0_110: begin alu_ctrl_o = ALU_OR;  illegal_o = 1'b0; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered ALU control stage: decode plus valid/ready handshake with a one-entry skid buffer.
// Optional saturating illegal-op counter enabled by `define ALU_CTRL_ILLEGAL_CNT_EN.
module alu_ctrl_stage
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned ILLEGAL_CNT_W = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] op_class,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] alu_ctrl,
  output logic       illegal
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  ,
  output logic [ILLEGAL_CNT_W-1:0] illegal_count
`endif
);

  stage_entry_t out_q, out_d;
  stage_entry_t skid_q, skid_d;
  logic [3:0]   dec_ctrl;
  logic         dec_illegal;
  logic         in_xfer;
  logic         out_free;

  alu_ctrl_decode u_decode (
    .op_class_i (op_class),
    .funct7_5_i (funct7_5),
    .funct3_i   (funct3),
    .alu_ctrl_o (dec_ctrl),
    .illegal_o  (dec_illegal)
  );

  // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally.
  assign in_ready = !skid_q.valid;
  assign in_xfer  = in_valid && in_ready;
  assign out_free = !out_q.valid || out_ready;

  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    if (out_free) begin
      if (skid_q.valid) begin
        out_d        = skid_q;
        skid_d.valid = 1'b0;
      end else if (in_xfer) begin
        out_d = '{valid: 1'b1, alu_ctrl: dec_ctrl, illegal: dec_illegal};
      end else begin
        out_d.valid = 1'b0;
      end
    end else if (in_xfer) begin
      skid_d = '{valid: 1'b1, alu_ctrl: dec_ctrl, illegal: dec_illegal};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      out_q  <= out_d;
      skid_q <= skid_d;
    end
  end

  assign out_valid = out_q.valid;
  assign alu_ctrl  = out_q.alu_ctrl;
  assign illegal   = out_q.illegal;

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  logic [ILLEGAL_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_q.valid && out_ready && out_q.illegal && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign illegal_count = cnt_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed and random self-checking bench for alu_ctrl_stage.
module tb_alu_ctrl_stage;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] op_class = 2'b00;
  logic [2:0] funct3 = 3'b000;
  logic       funct7_5 = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] alu_ctrl;
  logic       illegal;

  int total = 0;
  int bad = 0;
  int delivered = 0;
  logic [4:0] q[$];
  logic [4:0] got[$];

  always #5 clk = ~clk;

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  localparam int unsigned CW = 4;
  logic [CW-1:0] illegal_count;

  alu_ctrl_stage #(.ILLEGAL_CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_class(op_class), .funct3(funct3), .funct7_5(funct7_5),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .illegal(illegal), .illegal_count(illegal_count)
  );
`else
  alu_ctrl_stage dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_class(op_class), .funct3(funct3), .funct7_5(funct7_5),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .illegal(illegal)
  );
`endif

  // Reference decode: {illegal, alu_ctrl}
  function automatic logic [4:0] model(input logic [1:0] oc, input logic f7, input logic [2:0] f3);
    if (oc == 2'b00) return 5'b0_0010;
    if (oc == 2'b01) return 5'b0_0110;
    if (oc == 2'b10) begin
      if (!f7 && f3 == 3'b000) return 5'b0_0010;
      if ( f7 && f3 == 3'b000) return 5'b0_0110;
      if (!f7 && f3 == 3'b111) return 5'b0_0000;
      if (!f7 && f3 == 3'b110) return 5'b0_0001;
    end
    return 5'b1_1100;
  endfunction

  // Advance one clock, logging handshakes seen just before the edge into the scoreboard.
  task automatic cycle();
    logic [4:0] exp;
    if (in_valid && in_ready) q.push_back(model(op_class, funct7_5, funct3));
    if (out_valid && out_ready) begin
      total++;
      delivered++;
      got.push_back({illegal, alu_ctrl});
      if (q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra got=%b expected=none", {illegal, alu_ctrl});
      end else begin
        exp = q.pop_front();
        if ({illegal, alu_ctrl} !== exp) begin
          bad++;
          $display("FAIL sb_order got=%b expected=%b", {illegal, alu_ctrl}, exp);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; out_ready = i[0]; op_class = 2'(i); funct3 = 3'(i); funct7_5 = i[1];
      @(posedge clk); #1;
      total++;
      if ({out_valid, alu_ctrl, illegal, in_ready} !== 7'b0_0000_0_1) begin
        bad++;
        $display("FAIL reset_state got=%b expected=%b", {out_valid, alu_ctrl, illegal, in_ready}, 7'b0_0000_0_1);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset got=%b expected=0", out_valid);
    end
    in_valid = 1'b1; op_class = 2'b10; funct7_5 = 1'b1; funct3 = 3'b000;
    cycle();
    total++;
    if ({out_valid, alu_ctrl} !== 5'b1_0110) begin
      bad++; $display("FAIL first_latency got=%b expected=%b", {out_valid, alu_ctrl}, 5'b1_0110);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL drain_empty got=%b expected=0", out_valid);
    end
  endtask

  task automatic test_sweep();
    logic [5:0] v;
    delivered = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      v = 6'(i);
      op_class = v[5:4]; funct7_5 = v[3]; funct3 = v[2:0];
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    total++;
    if (delivered !== 64 || q.size() != 0) begin
      bad++; $display("FAIL sweep_count got=%0d expected=64 left=%0d", delivered, q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_seq[4] = '{5'b0_0010, 5'b0_0110, 5'b0_0000, 5'b0_0001};
    got.delete();
    in_valid = 1'b1; out_ready = 1'b1;
    op_class = 2'b10; funct7_5 = 1'b0; funct3 = 3'b000; cycle();
    funct7_5 = 1'b1; funct3 = 3'b000; cycle();
    out_ready = 1'b0;
    funct7_5 = 1'b0; funct3 = 3'b111; cycle();
    funct3 = 3'b110;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({in_ready, out_valid, alu_ctrl} !== 6'b0_1_0110) begin
        bad++; $display("FAIL stall_hold got=%b expected=%b", {in_ready, out_valid, alu_ctrl}, 6'b0_1_0110);
      end
      if (i < 3) cycle();
    end
    out_ready = 1'b1;
    cycle();
    total++;
    if ({in_ready, alu_ctrl} !== 5'b1_0000) begin
      bad++; $display("FAIL skid_drain got=%b expected=%b", {in_ready, alu_ctrl}, 5'b1_0000);
    end
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    total++;
    if (got.size() != 4) begin
      bad++; $display("FAIL bp_count got=%0d expected=4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got[i] !== exp_seq[i]) begin
          bad++; $display("FAIL bp_seq idx=%0d got=%b expected=%b", i, got[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic ir;
    for (int i = 0; i < 10000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      op_class = 2'($urandom); funct3 = 3'($urandom); funct7_5 = 1'($urandom);
      total++;
      if (in_ready !== (q.size() < 2) || out_valid !== (q.size() != 0)) begin
        bad++;
        $display("FAIL rand_occupancy got=%b%b expected_count=%0d", in_ready, out_valid, q.size());
      end
      ir = in_ready;
      out_ready = ~out_ready;
      #1;
      total++;
      if (in_ready !== ir) begin
        bad++; $display("FAIL in_ready_comb got=%b expected=%b", in_ready, ir);
      end
      out_ready = ~out_ready;
      #1;
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    total++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rand_drain got=%0d expected=0", q.size());
    end
  endtask

  task automatic test_midreset();
    out_ready = 1'b0; in_valid = 1'b1;
    op_class = 2'b00; cycle();
    op_class = 2'b01; cycle();
    total++;
    if ({in_ready, out_valid} !== 2'b01) begin
      bad++; $display("FAIL pre_reset_full got=%b expected=01", {in_ready, out_valid});
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({out_valid, alu_ctrl, illegal, in_ready} !== 7'b0_0000_0_1) begin
      bad++; $display("FAIL async_reset got=%b expected=%b", {out_valid, alu_ctrl, illegal, in_ready}, 7'b0_0000_0_1);
    end
    q.delete();
    in_valid = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b1; op_class = 2'b10; funct7_5 = 1'b0; funct3 = 3'b110;
    cycle();
    total++;
    if ({out_valid, alu_ctrl} !== 5'b1_0001) begin
      bad++; $display("FAIL post_reset_first got=%b expected=%b", {out_valid, alu_ctrl}, 5'b1_0001);
    end
    in_valid = 1'b0;
    cycle();
  endtask

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  task automatic test_counter();
    reset_n = 1'b0; #2; reset_n = 1'b1;
    q.delete();
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b0; op_class = 2'b11;
    cycle();
    in_valid = 1'b0;
    cycle(); cycle();
    total++;
    if ({illegal, illegal_count} !== {1'b1, 4'd0}) begin
      bad++; $display("FAIL cnt_stalled got=%b expected=%b", {illegal, illegal_count}, {1'b1, 4'd0});
    end
    out_ready = 1'b1;
    cycle();
    total++;
    if (illegal_count !== 4'd1) begin
      bad++; $display("FAIL cnt_first got=%0d expected=1", illegal_count);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 19; i++) cycle();
    in_valid = 1'b0;
    cycle(); cycle();
    total++;
    if (illegal_count !== 4'd15) begin
      bad++; $display("FAIL cnt_saturate got=%0d expected=15", illegal_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sweep();
    test_back_to_back();
    test_random();
    test_midreset();
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    test_counter();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
